// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter: round-robin writeback arbiter with eop packet lock and one registered output stage.
// Defining WB_ARB_PERF_EN adds the saturating perf_stalls counter port.
module vx_wb_arbiter #(
    parameter int NUM_REQS    = 5,
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int REQ_BITS    = $clog2(NUM_REQS)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_REQS-1:0]                        req_valid,
    input  logic [NUM_REQS-1:0][NW_BITS-1:0]           req_wid,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0]       req_tmask,
    input  logic [NUM_REQS-1:0][31:0]                  req_pc,
    input  logic [NUM_REQS-1:0][4:0]                   req_rd,
    input  logic [NUM_REQS-1:0][NUM_THREADS-1:0][31:0] req_data,
    input  logic [NUM_REQS-1:0]                        req_eop,
    output logic [NUM_REQS-1:0]                        req_ready,
    output logic                                       wb_valid,
    output logic [NW_BITS-1:0]                         wb_wid,
    output logic [NUM_THREADS-1:0]                     wb_tmask,
    output logic [31:0]                                wb_pc,
    output logic [4:0]                                 wb_rd,
    output logic [NUM_THREADS-1:0][31:0]               wb_data,
    output logic                                       wb_eop,
    output logic [REQ_BITS-1:0]                        wb_src,
    input  logic                                       wb_ready
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]                                perf_stalls
`endif
);
    logic                en;
    logic                found;
    logic                grant;
    logic                lock;
    logic [REQ_BITS-1:0] sel;
    logic [REQ_BITS-1:0] cand;
    logic [REQ_BITS-1:0] last_grant;
    logic [REQ_BITS-1:0] owner;

    assign en    = !wb_valid || wb_ready;
    assign grant = reset && en && found;

    // Descending scan so the source closest after last_grant is assigned last and wins.
    always_comb begin
        found = 1'b0;
        sel   = owner;
        cand  = '0;
        if (lock) begin
            found = req_valid[owner];
        end else begin
            for (int k = NUM_REQS; k >= 1; k--) begin
                cand = REQ_BITS'((int'(last_grant) + k) % NUM_REQS);
                if (req_valid[cand]) begin
                    found = 1'b1;
                    sel   = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid   <= 1'b0;
            wb_wid     <= '0;
            wb_tmask   <= '0;
            wb_pc      <= '0;
            wb_rd      <= '0;
            wb_data    <= '0;
            wb_eop     <= 1'b0;
            wb_src     <= '0;
            lock       <= 1'b0;
            owner      <= '0;
            last_grant <= REQ_BITS'(NUM_REQS - 1);
        end else if (en) begin
            wb_valid <= grant;
            if (grant) begin
                wb_wid     <= req_wid[sel];
                wb_tmask   <= req_tmask[sel];
                wb_pc      <= req_pc[sel];
                wb_rd      <= req_rd[sel];
                wb_data    <= req_data[sel];
                wb_eop     <= req_eop[sel];
                wb_src     <= sel;
                last_grant <= sel;
                lock       <= !req_eop[sel];
                owner      <= sel;
            end
        end
    end

`ifdef WB_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            perf_stalls <= '0;
        else if (|(req_valid & ~req_ready) && perf_stalls != '1)
            perf_stalls <= perf_stalls + 32'd1;
    end
`endif
endmodule
